// File: rtl/seq_match_monitor_if.sv
// ============================================================================
//  Module   : seq_match_monitor_if
//  Purpose  : Report port of the windowed match monitor. The monitor offers
//             each closed window's match count; the consumer takes it with a
//             valid/ready handshake.
//  Signals  : rpt_valid  - report available (monitor -> consumer)
//             rpt_count  - closed-window match count, CNT_W bits
//             rpt_ready  - consumer accepts the report (consumer -> monitor)
//  Modports : master (monitor side), slave (consumer side)
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface seq_match_monitor_if #(
   parameter int CNT_W = 8
);
   logic             rpt_valid;
   logic [CNT_W-1:0] rpt_count;
   logic             rpt_ready;

   modport master (
      output rpt_valid,
      output rpt_count,
      input  rpt_ready
   );

   modport slave (
      input  rpt_valid,
      input  rpt_count,
      output rpt_ready
   );
endinterface

`default_nettype wire

// File: rtl/seq_match_monitor.sv
// ============================================================================
//  Module   : seq_match_monitor
//  Purpose  : Windowed monitor for the sequence detector's one-cycle match
//             flag. Rising-edge qualifies the flag, counts matches per
//             programmable window (win_len_i+1 cycles), keeps a saturating
//             lifetime total, raises a per-window threshold alarm and offers
//             each closed window's count on a valid/ready report port.
//  Ports    : clk          - clock, rising edge
//             rst          - asynchronous reset, active low
//             en_i         - run enable
//             clr_i        - synchronous clear of counters, flags and report
//             det_in_i     - detector match flag
//             win_len_i    - window length minus one (WIN_W bits)
//             threshold_i  - alarm level, 0 disables (CNT_W bits)
//             busy_o       - high while running
//             match_cnt_o  - live count of the current window
//             total_cnt_o  - saturating lifetime count
//             alarm_o      - window count reached threshold
//             overrun_o    - sticky: a report was overwritten before taken
//             rpt_if       - report port (master modport)
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_match_monitor #(
   parameter int CNT_W = 8,
   parameter int WIN_W = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 en_i,
   input  logic                 clr_i,
   input  logic                 det_in_i,
   input  logic [WIN_W-1:0]     win_len_i,
   input  logic [CNT_W-1:0]     threshold_i,
   output logic                 busy_o,
   output logic [CNT_W-1:0]     match_cnt_o,
   output logic [CNT_W-1:0]     total_cnt_o,
   output logic                 alarm_o,
   output logic                 overrun_o,
   seq_match_monitor_if.master  rpt_if
);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

   localparam logic [CNT_W-1:0] C_CNT_ZERO = '0;
   localparam logic [WIN_W-1:0] C_WIN_ONE  = {{(WIN_W-1){1'b0}}, 1'b1};

   logic [0:0]       state_q,     state_d;
   logic             det_q,       det_d;
   logic [WIN_W-1:0] win_left_q,  win_left_d;
   logic [CNT_W-1:0] match_cnt_q, match_cnt_d;
   logic [CNT_W-1:0] total_cnt_q, total_cnt_d;
   logic             alarm_q,     alarm_d;
   logic             overrun_q,   overrun_d;
   logic             rpt_valid_q, rpt_valid_d;
   logic [CNT_W-1:0] rpt_count_q, rpt_count_d;

   logic             match;
   logic [CNT_W-1:0] match_sat;
   logic [CNT_W-1:0] total_sat;
   logic             win_close;

   // A level held high produces a single match on its first cycle.
   assign match = det_in_i & ~det_q;

   // Saturating increments: an all-ones counter holds its value.
   assign match_sat = (&match_cnt_q) ? match_cnt_q
                                     : match_cnt_q + {{(CNT_W-1){1'b0}}, match};
   assign total_sat = (&total_cnt_q) ? total_cnt_q
                                     : total_cnt_q + {{(CNT_W-1){1'b0}}, match};

   always_comb begin
      state_d     = state_q;
      det_d       = det_in_i;
      win_left_d  = win_left_q;
      match_cnt_d = match_cnt_q;
      total_cnt_d = total_cnt_q;
      alarm_d     = alarm_q;
      overrun_d   = overrun_q;
      rpt_valid_d = rpt_valid_q;
      rpt_count_d = rpt_count_q;
      win_close   = 1'b0;

      if (clr_i) begin
         // Clear wins over enable, matches and a coinciding window close.
         state_d     = ST_IDLE;
         det_d       = 1'b0;
         win_left_d  = '0;
         match_cnt_d = '0;
         total_cnt_d = '0;
         alarm_d     = 1'b0;
         overrun_d   = 1'b0;
         rpt_valid_d = 1'b0;
         rpt_count_d = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (en_i) begin
                  state_d     = ST_RUN;
                  win_left_d  = win_len_i;
                  match_cnt_d = '0;
                  alarm_d     = 1'b0;
               end
            end
            ST_RUN: begin
               if (!en_i) begin
                  // Abort: the partial window is dropped without a report.
                  state_d = ST_IDLE;
               end else begin
                  total_cnt_d = total_sat;
                  if (win_left_q == '0) begin
                     // Close: the final cycle's match belongs to this window.
                     win_close   = 1'b1;
                     rpt_count_d = match_sat;
                     rpt_valid_d = 1'b1;
                     if (rpt_valid_q && !rpt_if.rpt_ready) begin
                        overrun_d = 1'b1;
                     end
                     match_cnt_d = '0;
                     alarm_d     = 1'b0;
                     win_left_d  = win_len_i;
                  end else begin
                     match_cnt_d = match_sat;
                     win_left_d  = win_left_q - C_WIN_ONE;
                     if ((threshold_i != C_CNT_ZERO) && (match_sat >= threshold_i)) begin
                        alarm_d = 1'b1;
                     end
                  end
               end
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase

         // An accepted report retires unless a new one is loaded this cycle.
         if (!win_close && rpt_valid_q && rpt_if.rpt_ready) begin
            rpt_valid_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         det_q       <= 1'b0;
         win_left_q  <= '0;
         match_cnt_q <= '0;
         total_cnt_q <= '0;
         alarm_q     <= 1'b0;
         overrun_q   <= 1'b0;
         rpt_valid_q <= 1'b0;
         rpt_count_q <= '0;
      end else begin
         state_q     <= state_d;
         det_q       <= det_d;
         win_left_q  <= win_left_d;
         match_cnt_q <= match_cnt_d;
         total_cnt_q <= total_cnt_d;
         alarm_q     <= alarm_d;
         overrun_q   <= overrun_d;
         rpt_valid_q <= rpt_valid_d;
         rpt_count_q <= rpt_count_d;
      end
   end

   assign busy_o           = (state_q == ST_RUN);
   assign match_cnt_o      = match_cnt_q;
   assign total_cnt_o      = total_cnt_q;
   assign alarm_o          = alarm_q;
   assign overrun_o        = overrun_q;
   assign rpt_if.rpt_valid = rpt_valid_q;
   assign rpt_if.rpt_count = rpt_count_q;

endmodule

`default_nettype wire
